// File: rtl/lmc_seq.sv
// LMC front-panel sequencer: manual program entry (LOAD) and fetch/execute (RUN)
// for a 16x8 synchronous program RAM with an 8-bit accumulator.
module lmc_seq #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  timer555,
  input  logic                  reset_count,
  input  logic                  run_sw,
  input  logic                  RAM_button,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [ADDR_WIDTH-1:0] counter,
  output logic [DATA_WIDTH-1:0] acc,
  output logic [DATA_WIDTH-1:0] out_reg,
  output logic                  out_valid,
  output logic                  halted
);

  typedef enum logic [2:0] {
    S_LOAD, S_FETCH, S_FWAIT, S_DECODE, S_OPRD, S_OWAIT, S_EXEC, S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_LDA = 4'h5;
  localparam logic [3:0] OP_BRA = 4'h6;
  localparam logic [3:0] OP_BRZ = 4'h7;
  localparam logic [3:0] OP_BRP = 4'h8;
  localparam logic [3:0] OP_OUT = 4'h9;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_STA) || (op == OP_LDA);
  endfunction

  // MSB of the result is the borrow out of the subtraction.
  function automatic logic [DATA_WIDTH:0] sub_borrow(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_counter, w_counter_nxt;
  logic [DATA_WIDTH-1:0] r_acc, w_acc_nxt;
  logic [DATA_WIDTH-1:0] r_out, w_out_nxt;
  logic                  r_outv, w_outv_nxt;
  logic                  r_neg, w_neg_nxt;
  logic                  r_we_q;
  logic [DATA_WIDTH-1:0] r_ir;
  logic                  r_run_p0, r_run_p1, r_run_p2;
  logic                  r_btn_p0, r_btn_p1, r_btn_p2;

  logic                  w_run, w_run_rise, w_btn_pulse, w_in_run;
  logic [3:0]            w_opcode, w_dec_op;
  logic [ADDR_WIDTH-1:0] w_operand;
  logic [DATA_WIDTH:0]   w_diff;

  assign w_run       = r_run_p1;
  assign w_run_rise  = r_run_p1 & ~r_run_p2;
  assign w_btn_pulse = r_btn_p1 & ~r_btn_p2;
  assign w_in_run    = (r_state != S_LOAD) && (r_state != S_HALT);
  assign w_opcode    = r_ir[DATA_WIDTH-1 -: 4];
  assign w_operand   = r_ir[ADDR_WIDTH-1:0];
  assign w_dec_op    = ram_rdata[DATA_WIDTH-1 -: 4];
  assign w_diff      = sub_borrow(r_acc, ram_rdata);

  assign counter   = r_counter;
  assign acc       = r_acc;
  assign out_reg   = r_out;
  assign out_valid = r_outv;

  always_comb begin
    w_state_nxt   = r_state;
    w_counter_nxt = r_counter;
    w_acc_nxt     = r_acc;
    w_neg_nxt     = r_neg;
    w_out_nxt     = r_out;
    w_outv_nxt    = 1'b0;
    ram_addr      = r_counter;
    ram_we        = 1'b0;
    ram_wdata     = r_acc;
    halted        = 1'b0;
    case (r_state)
      S_LOAD: begin
        // r_we_q keeps a panel write from abutting a STA write just before abort
        if (w_btn_pulse && !r_we_q) begin
          ram_we        = 1'b1;
          ram_wdata     = data_in;
          w_counter_nxt = r_counter + 1'b1;
        end
        if (w_run_rise) begin
          w_state_nxt   = S_FETCH;
          w_counter_nxt = '0;
          w_acc_nxt     = '0;
          w_neg_nxt     = 1'b0;
        end
      end
      S_FETCH:  w_state_nxt = S_FWAIT;
      S_FWAIT:  w_state_nxt = S_DECODE;
      S_DECODE: begin
        w_counter_nxt = r_counter + 1'b1;
        w_state_nxt   = is_mem_op(w_dec_op) ? S_OPRD : S_EXEC;
      end
      S_OPRD: begin
        ram_addr    = w_operand;
        w_state_nxt = S_OWAIT;
      end
      S_OWAIT: begin
        ram_addr    = w_operand;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        ram_addr    = w_operand;
        w_state_nxt = S_FETCH;
        case (w_opcode)
          OP_ADD: begin w_acc_nxt = r_acc + ram_rdata; w_neg_nxt = 1'b0; end
          OP_SUB: begin w_acc_nxt = w_diff[DATA_WIDTH-1:0]; w_neg_nxt = w_diff[DATA_WIDTH]; end
          OP_STA: ram_we = 1'b1;
          OP_LDA: begin w_acc_nxt = ram_rdata; w_neg_nxt = 1'b0; end
          OP_BRA: w_counter_nxt = w_operand;
          OP_BRZ: if (r_acc == '0) w_counter_nxt = w_operand;
          OP_BRP: if (!r_neg) w_counter_nxt = w_operand;
          OP_OUT: begin w_out_nxt = r_acc; w_outv_nxt = 1'b1; end
          default: w_state_nxt = S_HALT;
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
        if (!w_run) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_LOAD;
    endcase
    // Abort back to LOAD; any write already on the bus this cycle still completes.
    if (w_in_run && !w_run) begin
      w_state_nxt   = S_LOAD;
      w_counter_nxt = '0;
      w_acc_nxt     = r_acc;
      w_neg_nxt     = r_neg;
      w_out_nxt     = r_out;
      w_outv_nxt    = 1'b0;
    end
  end

  always_ff @(posedge timer555 or posedge reset_count) begin
    if (reset_count) begin
      r_state   <= S_LOAD;
      r_counter <= '0;
      r_acc     <= '0;
      r_neg     <= 1'b0;
      r_out     <= '0;
      r_outv    <= 1'b0;
      r_we_q    <= 1'b0;
      r_run_p0  <= 1'b0;
      r_run_p1  <= 1'b0;
      r_run_p2  <= 1'b0;
      r_btn_p0  <= 1'b0;
      r_btn_p1  <= 1'b0;
      r_btn_p2  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_counter <= w_counter_nxt;
      r_acc     <= w_acc_nxt;
      r_neg     <= w_neg_nxt;
      r_out     <= w_out_nxt;
      r_outv    <= w_outv_nxt;
      r_we_q    <= ram_we;
      r_run_p0  <= run_sw;
      r_run_p1  <= r_run_p0;
      r_run_p2  <= r_run_p1;
      r_btn_p0  <= RAM_button;
      r_btn_p1  <= r_btn_p0;
      r_btn_p2  <= r_btn_p1;
    end
  end

  always_ff @(posedge timer555) begin
    if (r_state == S_DECODE) r_ir <= ram_rdata;
  end

endmodule

// File: tb/tb_lmc_seq.sv
// Bench for lmc_seq: directed program table, hand-written corner sequences and
// random programs checked against an instruction-level LMC model.
module tb_lmc_seq;

  logic       timer555 = 1'b0;
  logic       reset_count = 1'b1;
  logic       run_sw = 1'b0;
  logic       RAM_button = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] ram_rdata;
  logic [3:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [3:0] counter;
  logic [7:0] acc;
  logic [7:0] out_reg;
  logic       out_valid;
  logic       halted;

  always #5 timer555 = ~timer555;

  lmc_seq #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .timer555(timer555), .reset_count(reset_count), .run_sw(run_sw),
    .RAM_button(RAM_button), .data_in(data_in), .ram_rdata(ram_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .counter(counter), .acc(acc), .out_reg(out_reg), .out_valid(out_valid),
    .halted(halted)
  );

  // Synchronous 16x8 program RAM
  logic [7:0] mem [16];
  always @(posedge timer555) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int         n_checks = 0;
  int         n_fail = 0;
  int         we_count = 0;
  int         we_consec = 0;
  logic       we_prev = 1'b0;
  logic [7:0] outq [$];

  always @(negedge timer555) begin
    if (ram_we) begin
      we_count++;
      if (we_prev) we_consec++;
    end
    we_prev = ram_we;
    if (out_valid) outq.push_back(out_reg);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_count = 1'b1;
    run_sw      = 1'b0;
    RAM_button  = 1'b0;
    repeat (2) @(posedge timer555);
    #1 reset_count = 1'b0;
    outq.delete();
    repeat (3) @(posedge timer555);
    #1;
  endtask

  task automatic press(input logic [7:0] d, input int hold);
    @(posedge timer555);
    #1 data_in = d;
    RAM_button = 1'b1;
    repeat (hold) @(posedge timer555);
    #1 RAM_button = 1'b0;
    repeat (3) @(posedge timer555);
    #1;
  endtask

  task automatic load_prog(input logic [15:0][7:0] p);
    for (int i = 0; i < 16; i++) press(p[i], 3);
  endtask

  // Run is seen by the sequencer three edges after run_sw rises, so FETCH
  // starts at edge 3; cycles to HALT entry are the edges waited minus 3.
  task automatic run_wait(input int budget, output int cyc, output bit ok);
    int n;
    @(posedge timer555);
    #1 run_sw = 1'b1;
    n = 0;
    while (!halted && n < budget) begin
      @(posedge timer555);
      #1;
      n++;
    end
    ok  = halted;
    cyc = n - 3;
    if (!ok) check("halt_timeout", 32'd0, 32'd1);
  endtask

  // Instruction-level reference model
  logic [15:0][7:0] m_mem;
  logic [7:0]       m_acc;
  logic [3:0]       m_pc;
  int               m_cyc;
  bit               m_halt;
  logic [7:0]       m_outs [$];

  task automatic model_run(input logic [15:0][7:0] p, input int max_instr);
    logic       neg;
    logic [7:0] ir;
    logic [3:0] op, a;
    m_mem = p; m_acc = 8'h00; m_pc = 4'h0; neg = 1'b0;
    m_cyc = 0; m_halt = 1'b0; m_outs.delete();
    for (int k = 0; k < max_instr && !m_halt; k++) begin
      ir   = m_mem[m_pc];
      m_pc = m_pc + 4'd1;
      op   = ir[7:4];
      a    = ir[3:0];
      case (op)
        4'h1: begin m_cyc += 6; m_acc = m_acc + m_mem[a]; neg = 1'b0; end
        4'h2: begin m_cyc += 6; neg = (m_acc < m_mem[a]); m_acc = m_acc - m_mem[a]; end
        4'h3: begin m_cyc += 6; m_mem[a] = m_acc; end
        4'h5: begin m_cyc += 6; m_acc = m_mem[a]; neg = 1'b0; end
        4'h6: begin m_cyc += 4; m_pc = a; end
        4'h7: begin m_cyc += 4; if (m_acc == 8'h00) m_pc = a; end
        4'h8: begin m_cyc += 4; if (!neg) m_pc = a; end
        4'h9: begin m_cyc += 4; m_outs.push_back(m_acc); end
        default: begin m_cyc += 4; m_halt = 1'b1; end
      endcase
    end
  endtask

  typedef struct {
    logic [15:0][7:0] prog;
    logic [7:0]       acc;
    logic [3:0]       pc;
    int               nout;
    logic [7:0]       last_out;
    logic [7:0]       m15;
    int               cyc;
  } vec_t;

  vec_t       vecs [3];
  logic [3:0] ops [8] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0][7:0] p;
    int               cyc, wc;
    bit               ok;

    // LDA 14 / ADD 15 / OUT / HLT
    vecs[0].prog = '0;
    vecs[0].prog[0] = 8'h5E; vecs[0].prog[1] = 8'h1F; vecs[0].prog[2] = 8'h90;
    vecs[0].prog[3] = 8'h00; vecs[0].prog[14] = 8'hF0; vecs[0].prog[15] = 8'h20;
    vecs[0].acc = 8'h10; vecs[0].pc = 4'd4; vecs[0].nout = 1; vecs[0].last_out = 8'h10;
    vecs[0].m15 = 8'h20; vecs[0].cyc = 20;
    // Count-down loop with STA / BRZ / BRA
    vecs[1].prog = '0;
    vecs[1].prog[0] = 8'h5F; vecs[1].prog[1] = 8'h2E; vecs[1].prog[2] = 8'h3F;
    vecs[1].prog[3] = 8'h75; vecs[1].prog[4] = 8'h60; vecs[1].prog[5] = 8'h00;
    vecs[1].prog[14] = 8'h01; vecs[1].prog[15] = 8'h03;
    vecs[1].acc = 8'h00; vecs[1].pc = 4'd6; vecs[1].nout = 0; vecs[1].last_out = 8'h00;
    vecs[1].m15 = 8'h00; vecs[1].cyc = 78;
    // SUB underflow: BRP not taken; after LDA, BRP taken
    vecs[2].prog = '0;
    vecs[2].prog[0] = 8'h5E; vecs[2].prog[1] = 8'h2F; vecs[2].prog[2] = 8'h86;
    vecs[2].prog[3] = 8'h90; vecs[2].prog[4] = 8'h5E; vecs[2].prog[5] = 8'h87;
    vecs[2].prog[6] = 8'h00; vecs[2].prog[7] = 8'h90; vecs[2].prog[8] = 8'h00;
    vecs[2].prog[14] = 8'h02; vecs[2].prog[15] = 8'h05;
    vecs[2].acc = 8'h02; vecs[2].pc = 4'd9; vecs[2].nout = 2; vecs[2].last_out = 8'h02;
    vecs[2].m15 = 8'h05; vecs[2].cyc = 38;

    do_reset();
    check("reset_counter", 32'(counter), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_acc", 32'(acc), 32'd0);

    for (int t = 0; t < 3; t++) begin
      do_reset();
      load_prog(vecs[t].prog);
      run_wait(200, cyc, ok);
      check($sformatf("vec%0d_halted", t), 32'(halted), 32'd1);
      check($sformatf("vec%0d_acc", t), 32'(acc), 32'(vecs[t].acc));
      check($sformatf("vec%0d_counter", t), 32'(counter), 32'(vecs[t].pc));
      check($sformatf("vec%0d_out_reg", t), 32'(out_reg), 32'(vecs[t].last_out));
      check($sformatf("vec%0d_nout", t), 32'(outq.size()), 32'(vecs[t].nout));
      check($sformatf("vec%0d_m15", t), 32'(mem[15]), 32'(vecs[t].m15));
      check($sformatf("vec%0d_cycles", t), 32'(cyc), 32'(vecs[t].cyc));
    end
    check("brp_first_out", 32'(outq[0]), 32'hFD);

    // 17 presses: address 0 is rewritten and the counter wraps to 1
    do_reset();
    wc = we_count;
    for (int i = 0; i < 17; i++) press(8'(i + 1), 3);
    check("load17_writes", 32'(we_count - wc), 32'd17);
    check("load17_counter", 32'(counter), 32'd1);
    check("load17_m0", 32'(mem[0]), 32'h11);
    for (int i = 1; i < 16; i++) check($sformatf("load17_m%0d", i), 32'(mem[i]), 32'(i + 1));
    wc = we_count;
    press(8'hAB, 10);
    check("held_btn_writes", 32'(we_count - wc), 32'd1);
    check("held_btn_counter", 32'(counter), 32'd2);
    check("held_btn_m1", 32'(mem[1]), 32'hAB);

    // Reset in the middle of a run
    do_reset();
    p = '0; p[0] = 8'h5E; p[1] = 8'h61; p[14] = 8'h12;
    load_prog(p);
    @(posedge timer555);
    #1 run_sw = 1'b1;
    repeat (30) @(posedge timer555);
    #3;
    check("midrun_acc", 32'(acc), 32'h12);
    reset_count = 1'b1;
    #1;
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_counter", 32'(counter), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_out_reg", 32'(out_reg), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    run_sw = 1'b0;
    @(posedge timer555);
    #1 reset_count = 1'b0;
    press(8'hA5, 3);
    check("rst_load_m0", 32'(mem[0]), 32'hA5);
    check("rst_load_counter", 32'(counter), 32'd1);

    // Abort while STA waits for its operand
    do_reset();
    p = '0; p[0] = 8'h5E; p[1] = 8'h3F; p[2] = 8'h00; p[14] = 8'h77; p[15] = 8'h00;
    load_prog(p);
    wc = we_count;
    @(posedge timer555);
    #1 run_sw = 1'b1;
    repeat (11) @(posedge timer555);
    #1 run_sw = 1'b0;
    repeat (3) @(posedge timer555);
    #1;
    check("abort_counter", 32'(counter), 32'd0);
    check("abort_halted", 32'(halted), 32'd0);
    check("abort_acc", 32'(acc), 32'h77);
    repeat (5) @(posedge timer555);
    #1;
    check("abort_no_write", 32'(we_count - wc), 32'd0);
    check("abort_m15", 32'(mem[15]), 32'h00);
    run_wait(100, cyc, ok);
    check("rerun_m15", 32'(mem[15]), 32'h77);
    check("rerun_counter", 32'(counter), 32'd3);
    check("rerun_cycles", 32'(cyc), 32'd16);

    // Random programs against the model
    for (int it = 0; it < 20; it++) begin
      for (int tries = 0; tries < 100; tries++) begin
        for (int i = 0; i < 16; i++) begin
          if ($urandom_range(0, 9) < 8) p[i] = {ops[$urandom_range(0, 7)], 4'($urandom)};
          else p[i] = 8'($urandom);
        end
        model_run(p, 60);
        if (m_halt) break;
      end
      if (!m_halt) begin
        p[0] = 8'h00;
        model_run(p, 60);
      end
      do_reset();
      load_prog(p);
      run_wait(m_cyc + 30, cyc, ok);
      check($sformatf("rnd%0d_acc", it), 32'(acc), 32'(m_acc));
      check($sformatf("rnd%0d_counter", it), 32'(counter), 32'(m_pc));
      check($sformatf("rnd%0d_cycles", it), 32'(cyc), 32'(m_cyc));
      check($sformatf("rnd%0d_nout", it), 32'(outq.size()), 32'(m_outs.size()));
      for (int j = 0; j < outq.size() && j < m_outs.size(); j++)
        check($sformatf("rnd%0d_out%0d", it, j), 32'(outq[j]), 32'(m_outs[j]));
      for (int i = 0; i < 16; i++)
        check($sformatf("rnd%0d_mem%0d", it, i), 32'(mem[i]), 32'(m_mem[i]));
    end

    check("we_back_to_back", 32'(we_consec), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lmc_seq.md
Name: lmc_seq

Overview:
- Control sequencer for the LMC 16x8 program RAM and address counter. Two modes:
  - LOAD: manual program entry. The push-button writes data_in at the counter address, then the counter auto-increments.
  - RUN: fetch/execute sequencing of a reduced LMC instruction set with an 8-bit accumulator.
- Sits between the front-panel switches/button and the RAM. It is the only master of the RAM address, write-enable and write-data lines.

Parameters:
- ADDR_WIDTH, 4, RAM address / program-counter width (16 words).
- DATA_WIDTH, 8, RAM word / accumulator width; opcode = word[7:4], operand address = word[3:0].

Ports:
- timer555  input  1  system clock, rising edge.
- reset_count  input  1  asynchronous active-high reset.
- run_sw  input  1  mode switch, asynchronous level; 1 = RUN, 0 = LOAD.
- RAM_button  input  1  asynchronous load push-button, active high.
- data_in  input  DATA_WIDTH  panel data switches.
- ram_rdata  input  DATA_WIDTH  RAM read data; synchronous RAM, valid 1 cycle after ram_addr.
- ram_addr  output  ADDR_WIDTH  RAM address.
- ram_we  output  1  RAM write strobe, one cycle wide.
- ram_wdata  output  DATA_WIDTH  RAM write data.
- counter  output  ADDR_WIDTH  program counter / load address.
- acc  output  DATA_WIDTH  accumulator.
- out_reg  output  DATA_WIDTH  OUT instruction register.
- out_valid  output  1  one-cycle pulse when out_reg is updated.
- halted  output  1  high while in HALT.

Behaviour:
- Reset (async, reset_count=1):
  - state=LOAD; counter, acc, out_reg and ram_addr = 0; ram_we, out_valid and halted = 0; neg flag = 0.
  - Synchronizer flops cleared.
- run_sw and RAM_button each pass through a 2-flop synchronizer. RAM_button is rising-edge detected (btn_pulse); a held button yields exactly one pulse.
- LOAD state:
  - ram_addr = counter.
  - On btn_pulse: ram_we=1 and ram_wdata=data_in for one cycle; counter increments on the same edge. Wrap is 15 -> 0.
  - On sync run_sw rising: counter=0, acc=0, neg=0, go to FETCH. If btn_pulse and run rising occur in the same cycle, the write happens and then RUN begins with counter=0.
- RUN states:
  - FETCH: ram_addr=counter.
  - FWAIT: wait for RAM latency.
  - DECODE: IR=ram_rdata; counter += 1 (wraps).
  - Memory-operand ops go DECODE -> OPRD (ram_addr=IR[3:0]) -> OWAIT -> EXEC. All other ops go DECODE -> EXEC.
  - EXEC returns to FETCH, except HLT and undefined opcodes, which go to HALT.
- Instruction cycle counts (FETCH to next FETCH): memory ops = 6 cycles; others = 4 cycles.
- Opcodes (IR[7:4]):
  - 0 HLT: go to HALT.
  - 1 ADD: acc = acc + M mod 256; neg=0.
  - 2 SUB: acc = acc - M mod 256; neg = borrow.
  - 3 STA: ram_we=1 at IR[3:0] with acc, in EXEC.
  - 5 LDA: acc=M; neg=0.
  - 6 BRA: counter=IR[3:0].
  - 7 BRZ: branch if acc==0.
  - 8 BRP: branch if neg==0.
  - 9 OUT: out_reg=acc; out_valid=1 for one cycle.
  - Others: treated as HLT.
- HALT: halted=1. Holds until sync run_sw=0, then state=LOAD, halted=0, counter unchanged.
- run_sw falling in any RUN state: abort at the next edge to LOAD with counter=0. A write already asserted that cycle completes.
- Button pulses outside LOAD are ignored.
- ram_we is never asserted for more than one consecutive cycle.

Test Plan:
- Reset mid-RUN (acc=0x12): all outputs return to 0; state=LOAD; ram_we=0 within the same cycle.
- LOAD 16 words: 17 button presses; addr 0 is rewritten by press 17, counter ends at 1; RAM holds the last values. A button held for 10 cycles yields one write.
- Program: 0:LDA 14 (0x5E), 1:ADD 15 (0x1F), 2:OUT (0x90), 3:HLT. M14=0x F0, M15=0x20. Run -> out_reg=0x10 with a single out_valid pulse, halted=1, counter=4; total of 6+6+4+4 cycles to HALT entry.
- Loop: 0:LDA 15, 1:SUB 14, 2:STA 15, 3:BRZ 5, 4:BRA 0, 5:HLT. M14=1, M15=3. Run -> M15 ends at 0; BRZ taken once; halted with counter=6.
- BRP after SUB underflow (acc 0x02 - 0x05): acc=0xFD, neg=1, branch not taken. After a subsequent LDA, neg=0 and BRP is taken.
- Drop run_sw during OWAIT of STA: no write occurs, LOAD at the next cycle with counter=0. Raising run_sw again restarts from address 0.
